// File: rtl/trng_collector.sv
// trng_collector: samples the RO raw bit, von Neumann debiases it, packs words for a valid/ready consumer.
// Optional repetition-count health test is compiled in when TRNG_HEALTH_EN is defined.
module trng_collector #(
    parameter int WORD_WIDTH = 32,
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  raw_bit,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [15:0]           dropped_bits,
    output logic                  health_fail
);
    localparam int PW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
    localparam int FW = $clog2(WORD_WIDTH + 1);

    if (WORD_WIDTH < 2 || SAMPLE_DIV < 1 || REP_LIMIT < 2) begin : g_bad_param
        $error("trng_collector: illegal parameter value");
    end

    typedef enum logic {PAIR_A, PAIR_B} state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic                  a_q, a_d;
    logic [FW-1:0]         fill_q, fill_d, fill_n;
    logic [WORD_WIDTH-1:0] shift_q, shift_d, shift_n;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [15:0]           drop_q, drop_d;
    logic                  strobe, emit, full, take, load;
    logic                  fail_q, fail_set;

    // Prescaler and pair FSM registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PAIR_A;
            presc_q <= '0;
            a_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            a_q     <= a_d;
        end
    end

    // Prescaler count and FSM next state; disabling returns to the start of a pair
    always_comb begin
        strobe  = enable && (presc_q == PW'(SAMPLE_DIV - 1));
        presc_d = (!enable || strobe) ? '0 : presc_q + PW'(1);
        state_d = !enable ? PAIR_A : !strobe ? state_q : (state_q == PAIR_A ? PAIR_B : PAIR_A);
        a_d     = (strobe && state_q == PAIR_A) ? raw_bit : a_q;
    end

    // Von Neumann output: a differing pair emits its first sample (held in a_q)
    always_comb begin
        emit = strobe && state_q == PAIR_B && raw_bit != a_q;
    end

    // Packing, word hand-off and drop counting; a word finishing on a free edge is loaded directly
    always_comb begin
        full    = fill_q == FW'(WORD_WIDTH);
        take    = emit && !full && !fail_q;
        shift_n = take ? {shift_q[WORD_WIDTH-2:0], a_q} : shift_q;
        fill_n  = take ? fill_q + FW'(1) : fill_q;
        load    = enable && fill_n == FW'(WORD_WIDTH) && (!valid_q || word_ready) && !fail_q && !fail_set;
        shift_d = enable ? shift_n : '0;
        fill_d  = (!enable || load) ? '0 : fill_n;
        data_d  = load ? shift_n : data_q;
        valid_d = (fail_q || fail_set) ? 1'b0 : load ? 1'b1 : (valid_q && word_ready) ? 1'b0 : valid_q;
        drop_d  = (emit && full && !fail_q && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            fill_q  <= fill_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

`ifdef TRNG_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT + 1);
    logic [RW-1:0] rep_q, rep_d, rep_n;
    logic          prev_q, prev_d, fail_d;

    // Repetition count: run length of identical samples, saturating at the trip limit
    always_comb begin
        rep_n    = (rep_q != '0 && raw_bit == prev_q) ? (rep_q == RW'(REP_LIMIT) ? rep_q : rep_q + RW'(1)) : RW'(1);
        rep_d    = !enable ? '0 : strobe ? rep_n : rep_q;
        prev_d   = strobe ? raw_bit : prev_q;
        fail_set = strobe && rep_n == RW'(REP_LIMIT);
        fail_d   = fail_q || fail_set;
    end

    // Health-test registers; the failure flag is sticky until reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rep_q  <= '0;
            prev_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            rep_q  <= rep_d;
            prev_q <= prev_d;
            fail_q <= fail_d;
        end
    end
`else
    assign fail_q   = 1'b0;
    assign fail_set = 1'b0;
`endif

    assign word_data    = data_q;
    assign word_valid   = valid_q;
    assign dropped_bits = drop_q;
    assign health_fail  = fail_q;
endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: directed vector bench for trng_collector (8-bit words, plus a SAMPLE_DIV=4 instance).
module tb_trng_collector;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0, raw = 1'b0, rdy = 1'b0;
    logic [7:0]  data;
    logic        vld, hf;
    logic [15:0] drop;
    logic        en2 = 1'b0, raw2 = 1'b0, rdy2 = 1'b0;
    logic [7:0]  data2;
    logic        vld2, hf2;
    logic [15:0] drop2;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trng_collector #(.WORD_WIDTH(8), .SAMPLE_DIV(1), .REP_LIMIT(8)) dut (
        .clock(clk), .reset_n(reset_n), .enable(en), .raw_bit(raw),
        .word_data(data), .word_valid(vld), .word_ready(rdy),
        .dropped_bits(drop), .health_fail(hf)
    );

    trng_collector #(.WORD_WIDTH(8), .SAMPLE_DIV(4), .REP_LIMIT(8)) dut4 (
        .clock(clk), .reset_n(reset_n), .enable(en2), .raw_bit(raw2),
        .word_data(data2), .word_valid(vld2), .word_ready(rdy2),
        .dropped_bits(drop2), .health_fail(hf2)
    );

    typedef struct {
        logic        en, raw, rdy;
        logic        vld;
        logic [7:0]  data;
        logic [15:0] drop;
    } vec_t;

    vec_t tv[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic a, input logic b);
        raw = a;
        step();
        raw = b;
        step();
    endtask

    task automatic feed_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) pair(v[i], ~v[i]);
    endtask

    task automatic sample4(input logic v);
        raw2 = ~v;
        repeat (3) step();
        raw2 = v;
        step();
    endtask

    initial begin
        logic [20:0] seq;
        logic [7:0]  b4;
        seq = 21'b10_01_00_10_10_11_01_01_10_01_0;
        for (int i = 0; i < 21; i++) begin
            tv[i].en   = 1'b1;
            tv[i].raw  = seq[20-i];
            tv[i].rdy  = 1'b1;
            tv[i].vld  = (i == 19);
            tv[i].data = (i >= 19) ? 8'hB2 : 8'h00;
            tv[i].drop = 16'd0;
        end

        repeat (2) step();
        chk("reset_valid", {31'd0, vld}, 32'd0);
        chk("reset_data", {24'd0, data}, 32'd0);
        chk("reset_drop", {16'd0, drop}, 32'd0);
        chk("reset_health", {31'd0, hf}, 32'd0);
        reset_n = 1'b1;
        step();

        // Debiasing and packing, with 00/11 pairs interleaved
        for (int i = 0; i < 21; i++) begin
            en  = tv[i].en;
            raw = tv[i].raw;
            rdy = tv[i].rdy;
            step();
            chk($sformatf("vec%0d_valid", i), {31'd0, vld}, {31'd0, tv[i].vld});
            chk($sformatf("vec%0d_data", i), {24'd0, data}, {24'd0, tv[i].data});
            chk($sformatf("vec%0d_drop", i), {16'd0, drop}, {16'd0, tv[i].drop});
        end

        // Backpressure: word held, shift fills, further bits dropped
        en = 1'b0;
        step();
        en = 1'b1;
        rdy = 1'b0;
        feed_byte(8'h5A);
        chk("bp_word1_valid", {31'd0, vld}, 32'd1);
        chk("bp_word1_data", {24'd0, data}, 32'h5A);
        feed_byte(8'hC3);
        chk("bp_hold_data", {24'd0, data}, 32'h5A);
        chk("bp_hold_drop", {16'd0, drop}, 32'd0);
        feed_byte(8'hFF);
        chk("bp_drop8", {16'd0, drop}, 32'd8);
        chk("bp_still_data", {24'd0, data}, 32'h5A);
        chk("bp_still_valid", {31'd0, vld}, 32'd1);
        rdy = 1'b1;
        raw = 1'b0;
        step();
        chk("bp_word2_valid", {31'd0, vld}, 32'd1);
        chk("bp_word2_data", {24'd0, data}, 32'hC3);
        step();
        chk("bp_word2_taken", {31'd0, vld}, 32'd0);

        // Asynchronous reset mid-word
        rdy = 1'b0;
        feed_byte(8'h96);
        chk("pre_rst_valid", {31'd0, vld}, 32'd1);
        pair(1'b1, 1'b0);
        pair(1'b0, 1'b1);
        pair(1'b1, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, vld}, 32'd0);
        chk("async_rst_data", {24'd0, data}, 32'd0);
        chk("async_rst_drop", {16'd0, drop}, 32'd0);
        #1 reset_n = 1'b1;
        rdy = 1'b1;
        feed_byte(8'h3C);
        chk("post_rst_valid", {31'd0, vld}, 32'd1);
        chk("post_rst_data", {24'd0, data}, 32'h3C);

        // Enable drop discards a partial word
        for (int i = 0; i < 5; i++) pair(1'b1, 1'b0);
        en = 1'b0;
        step();
        chk("en_low_valid", {31'd0, vld}, 32'd0);
        en = 1'b1;
        feed_byte(8'h4D);
        chk("en_word_valid", {31'd0, vld}, 32'd1);
        chk("en_word_data", {24'd0, data}, 32'h4D);
        chk("en_word_drop", {16'd0, drop}, 32'd0);

        // SAMPLE_DIV=4: only every 4th clock is sampled
        b4 = 8'hA7;
        rdy2 = 1'b1;
        en2 = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            sample4(b4[i]);
            sample4(~b4[i]);
        end
        sample4(b4[0]);
        raw2 = b4[0];
        repeat (3) step();
        chk("div4_not_yet", {31'd0, vld2}, 32'd0);
        raw2 = ~b4[0];
        step();
        chk("div4_valid", {31'd0, vld2}, 32'd1);
        chk("div4_data", {24'd0, data2}, 32'hA7);
        chk("div4_drop", {16'd0, drop2}, 32'd0);
        chk("div4_health", {31'd0, hf2}, 32'd0);

`ifdef TRNG_HEALTH_EN
        // Repetition-count health test
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        en = 1'b1;
        rdy = 1'b0;
        feed_byte(8'h55);
        chk("hl_word_valid", {31'd0, vld}, 32'd1);
        chk("hl_ok", {31'd0, hf}, 32'd0);
        raw = 1'b1;
        repeat (7) step();
        chk("hl_7_ok", {31'd0, hf}, 32'd0);
        chk("hl_7_valid", {31'd0, vld}, 32'd1);
        step();
        chk("hl_8_fail", {31'd0, hf}, 32'd1);
        chk("hl_8_valid", {31'd0, vld}, 32'd0);
        rdy = 1'b1;
        feed_byte(8'hF0);
        chk("hl_no_word", {31'd0, vld}, 32'd0);
        chk("hl_no_drop", {16'd0, drop}, 32'd0);
        chk("hl_sticky", {31'd0, hf}, 32'd1);
`else
        chk("health_tied", {31'd0, hf}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
